lm70_spi_responder: RTL and testbench
=====================================

Name: lm70_spi_responder

Overview:
Emulates an LM70-style SPI temperature sensor: the slave end of the 3-wire CS/SCK/SIO link driven by our on-chip LM70 reader.
- Serves a 16-bit read word (11-bit two's-complement temperature, 0.25 °C/LSB) on SIO.
- Then captures a 16-bit command word to enter or exit shutdown.
- Used for self-test loopback and as a bench/board stand-in for the real sensor.
- Oversamples CS/SCK in its own clk domain.

Parameters:
- ID_WORD, 16'h8100: read word returned while in shutdown.
- STATUS_BITS, 5'b11111: fixed trailer appended after the 11 temperature bits.

Ports:
- clk  in  1  oversampling clock; SCK half-period must be ≥4 clk.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n  in  1  chip select from master, active low, asynchronous to clk.
- sck  in  1  SPI clock from master, asynchronous to clk.
- sio_in  in  1  SIO input path (master write data).
- sio_out  out  1  SIO output path (read data).
- sio_oe  out  1  SIO output enable, 1 = drive.
- temp_in  in  11  new temperature, signed, 0.25 °C/LSB.
- temp_we  in  1  load strobe for temp_in.
- shutdown  out  1  current shutdown state.
- cmd_word  out  16  last complete command word received.
- frame_done  out  1  one-clk pulse when a frame ends.

Behaviour:
- Reset values: sio_out=1, sio_oe=0, shutdown=0, cmd_word=0, frame_done=0, temp_hold=0, bit_cnt=0, state=IDLE.
- Input conditioning:
  - cs_n, sck and sio_in each pass through a 2-flop synchronizer and a third flop for edge detection.
  - Pin-to-edge-pulse latency is 3 clk.
- Temperature holding register:
  - temp_we in IDLE: temp_hold<=temp_in next clk.
  - temp_we during a frame: value parked in pend register, applied on the clk after frame end. A later temp_we overwrites the pending value.
- Shift register (16b), loaded every clk while IDLE:
  - shutdown=0: load {temp_hold, STATUS_BITS}.
  - shutdown=1: load ID_WORD.
  - The MSB is therefore already valid before CS falls.
- sio_out = shift_reg[15] in READ; 1 otherwise.
- sio_oe = 1 only in READ.
- States:
  - IDLE -> READ on synced cs_n falling edge; bit_cnt=0.
  - READ: on each synced sck rising edge, bit_cnt++. On each sck falling edge, shift_reg<<=1 (sio_out updates 1 clk after the edge pulse). When bit_cnt reaches 16 on a rising edge -> WRITE and sio_oe drops the same clk.
  - WRITE: on each sck rising edge, cmd_sr<={cmd_sr[14:0], sio_in_sync}; bit_cnt++, saturating at 32. Rising edges beyond 32 are ignored.
  - Any state -> IDLE on synced cs_n rising edge. frame_done pulses for 1 clk if bit_cnt>0.
- Command decode on cs_n rising edge, only when bit_cnt==32:
  - cmd_word<=cmd_sr.
  - cmd_sr[7:0]==8'hFF: shutdown<=1.
  - cmd_sr[7:0]==8'h00: shutdown<=0.
  - Otherwise shutdown unchanged.
- Aborted frame (cs_n rises with bit_cnt<32): cmd_word and shutdown unchanged; frame_done still pulses if bit_cnt>0.
- SCK edges while cs_n high are ignored.
- Simultaneous cs_n rise and sck edge in the same clk: cs_n wins; the edge is discarded.
- Reset mid-frame: immediate return to reset values; the next frame starts clean.

Decomposition:
- Package lm70_pkg holds:
  - state enum IDLE/READ/WRITE;
  - READ_BITS=16, FRAME_BITS=32;
  - CMD_SHDN=8'hFF, CMD_RUN=8'h00.
- One sub-module, sync_edge_det: 2-flop synchronizer plus rise/fall pulse outputs, instantiated 3× (rise/fall unused for sio_in).

Test Plan:
- Reset, then 16-clk master frame -> sio_oe=0, sio_out=1, shutdown=0, cmd_word=0 throughout reset; sio_oe=0 with no cs_n activity.
- temp_we with temp_in=11'h064 (25 °C), then 16-bit read -> master samples 16'h0C9F; frame_done single pulse at CS rise.
- temp_in=11'h7D8 (-10 °C) -> read 16'hFB1F.
- 32-bit frame writing 16'h00FF -> cmd_word=16'h00FF, shutdown=1; next read returns 16'h8100. Write 16'h0000 -> shutdown=0; next read returns temperature again.
- temp_we(11'h064) during a frame that returns the previous 11'h7D8 -> current read 16'hFB1F; next read 16'h0C9F.
- Abort: cs_n rises after 8 bits, then after 24 bits of a 00FF write -> no cmd_word/shutdown change, frame_done pulses. sck toggled with cs_n high -> no state change, sio_oe stays 0.

Source files
------------

// File: rtl/lm70_pkg.sv
// Shared definitions for the LM70 SPI responder: state codes, frame
// geometry, command opcodes and the read-word builder.
package lm70_pkg;

    // Frame state codes
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t WRITE = 2'd2;

    // Frame geometry: 16 read bits, then 16 command bits
    localparam int unsigned READ_BITS  = 16;
    localparam int unsigned FRAME_BITS = 32;

    // Command low-byte opcodes
    localparam logic [7:0] CMD_SHDN = 8'hFF;
    localparam logic [7:0] CMD_RUN  = 8'h00;

    // Word presented on SIO: ID while shut down, else temperature plus trailer
    function automatic logic [15:0] read_word(
        input logic        shdn,
        input logic [10:0] temp,
        input logic [15:0] id_word,
        input logic [4:0]  status
    );
        logic [15:0] w;
        w = shdn ? id_word : {temp, status};
        return w;
    endfunction

endpackage

// File: rtl/lm70_spi_responder_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, plus a delay flop whose
// comparison yields registered one-clk rise/fall pulses (3 clk pin-to-pulse).
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic sync,
    output logic rise,
    output logic fall
);
    import lm70_pkg::*;

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state: shift the pin through the chain and compare the last two stages
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        dly_d  = sync_q;
        rise_d = sync_q & ~dly_q;
        fall_d = ~sync_q & dly_q;
    end

    // Synchronizer, delay and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync = sync_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/lm70_spi_responder.sv
// LM70-style SPI temperature sensor emulator (slave side of CS/SCK/SIO).
// Serves a 16-bit read word, then captures a 16-bit command word that can
// enter or leave shutdown. CS/SCK/SIO are oversampled in the clk domain.
module lm70_spi_responder #(
    parameter logic [15:0] ID_WORD     = 16'h8100,
    parameter logic [4:0]  STATUS_BITS = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        sio_in,
    output logic        sio_out,
    output logic        sio_oe,
    input  logic [10:0] temp_in,
    input  logic        temp_we,
    output logic        shutdown,
    output logic [15:0] cmd_word,
    output logic        frame_done
);
    import lm70_pkg::*;

    localparam logic [5:0] CNT_READ  = 6'(READ_BITS);
    localparam logic [5:0] CNT_FRAME = 6'(FRAME_BITS);

    // Conditioned pins
    logic cs_rise, cs_fall, cs_n_sync_unused;
    logic sck_rise, sck_fall, sck_sync_unused;
    logic sio_sync, sio_rise_unused, sio_fall_unused;

    sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (cs_n),
        .sync  (cs_n_sync_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (sck),
        .sync  (sck_sync_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (sio_in),
        .sync  (sio_sync),
        .rise  (sio_rise_unused),
        .fall  (sio_fall_unused)
    );

    // Frame state
    state_t      state_q,      state_d;
    logic [5:0]  bit_cnt_q,    bit_cnt_d;
    logic [15:0] shift_q,      shift_d;
    logic [15:0] cmd_sr_q,     cmd_sr_d;
    logic [15:0] cmd_word_q,   cmd_word_d;
    logic        shutdown_q,   shutdown_d;
    logic        frame_done_q, frame_done_d;

    // Temperature holding and pending-update registers
    logic [10:0] temp_hold_q,  temp_hold_d;
    logic [10:0] pend_q,       pend_d;
    logic        pend_vld_q,   pend_vld_d;

    // Temperature update: direct when idle, parked until the frame ends otherwise
    always_comb begin
        temp_hold_d = temp_hold_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        if (state_q == IDLE) begin
            if (temp_we) begin
                temp_hold_d = temp_in;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                temp_hold_d = pend_q;
                pend_vld_d  = 1'b0;
            end
        end else if (temp_we) begin
            pend_d     = temp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Frame FSM, shifters and command decode; a CS rise overrides any SCK edge
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        cmd_sr_d     = cmd_sr_q;
        cmd_word_d   = cmd_word_q;
        shutdown_d   = shutdown_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                shift_d = read_word(shutdown_q, temp_hold_q, ID_WORD, STATUS_BITS);
                if (cs_fall) begin
                    state_d   = READ;
                    bit_cnt_d = '0;
                end
            end
            READ: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q + 6'd1 == CNT_READ) begin
                        state_d = WRITE;
                    end
                end
                if (sck_fall) begin
                    shift_d = {shift_q[14:0], 1'b1};
                end
            end
            WRITE: begin
                if (sck_rise && (bit_cnt_q < CNT_FRAME)) begin
                    cmd_sr_d  = {cmd_sr_q[14:0], sio_sync};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame end discards any SCK edge seen in the same clk
        if (cs_rise && (state_q != IDLE)) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            shift_d      = shift_q;
            cmd_sr_d     = cmd_sr_q;
            frame_done_d = (bit_cnt_q != 6'd0);
            if (bit_cnt_q == CNT_FRAME) begin
                cmd_word_d = cmd_sr_q;
                if (cmd_sr_q[7:0] == CMD_SHDN) begin
                    shutdown_d = 1'b1;
                end else if (cmd_sr_q[7:0] == CMD_RUN) begin
                    shutdown_d = 1'b0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '1;
            cmd_sr_q     <= '0;
            cmd_word_q   <= '0;
            shutdown_q   <= 1'b0;
            frame_done_q <= 1'b0;
            temp_hold_q  <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            cmd_sr_q     <= cmd_sr_d;
            cmd_word_q   <= cmd_word_d;
            shutdown_q   <= shutdown_d;
            frame_done_q <= frame_done_d;
            temp_hold_q  <= temp_hold_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    assign sio_oe     = (state_q == READ);
    assign sio_out    = (state_q == READ) ? shift_q[15] : 1'b1;
    assign shutdown   = shutdown_q;
    assign cmd_word   = cmd_word_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Self-checking bench for lm70_spi_responder: directed vector table from the
// sensor's datasheet-style behaviour, hand sequences for reset/abort/idle SCK,
// and randomized frames checked against a frame-level reference model.
module tb_lm70_spi_responder;

    localparam int H = 8;   // SCK half-period in clk cycles

    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic        sck;
    logic        sio_in;
    logic        sio_out;
    logic        sio_oe;
    logic [10:0] temp_in;
    logic        temp_we;
    logic        shutdown;
    logic [15:0] cmd_word;
    logic        frame_done;

    int tests;
    int fails;
    int fd_cnt;

    lm70_spi_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .sck        (sck),
        .sio_in     (sio_in),
        .sio_out    (sio_out),
        .sio_oe     (sio_oe),
        .temp_in    (temp_in),
        .temp_we    (temp_we),
        .shutdown   (shutdown),
        .cmd_word   (cmd_word),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts clk cycles with frame_done high
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    typedef struct {
        int          nbits;
        logic [15:0] wdata;
        bit          we_pre;
        logic [10:0] pre_val;
        int          we_mid;
        logic [10:0] mid_val;
        logic [15:0] exp_rd;
        logic [15:0] exp_cmd;
        bit          exp_shdn;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_we(input logic [10:0] v);
        @(negedge clk);
        temp_in = v;
        temp_we = 1'b1;
        @(negedge clk);
        temp_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Master frame: samples SIO before each rising SCK, drives write bits after bit 16
    task automatic run_frame(input int nbits, input logic [15:0] wdata, input int we_mid,
                             input logic [10:0] mid_val, input bit drive_exp,
                             output logic [15:0] rdata, output int oe_bad, output int rst_bad);
        rdata   = '0;
        oe_bad  = 0;
        rst_bad = 0;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i >= 16) sio_in = (i < 32) ? wdata[31 - i] : 1'($urandom);
            @(negedge clk);
            if (i == we_mid) begin
                temp_in = mid_val;
                temp_we = 1'b1;
            end
            @(negedge clk);
            temp_we = 1'b0;
            repeat (H - 2) @(negedge clk);
            if (i < 16) rdata = {rdata[14:0], sio_out};
            if (drive_exp && (sio_oe !== (i < 16))) oe_bad++;
            if (!rst_n && (sio_oe !== 1'b0 || sio_out !== 1'b1 || shutdown !== 1'b0 || cmd_word !== 16'h0))
                rst_bad++;
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
        repeat (H) @(negedge clk);
        cs_n   = 1'b1;
        sio_in = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] exp_word;
        logic [15:0] wdata;
        logic [10:0] m_temp;
        logic [10:0] v;
        logic [10:0] mid_val;
        logic [15:0] m_cmd;
        logic        m_shdn;
        int          oe_bad;
        int          rst_bad;
        int          fd0;
        int          n;
        int          nbits;
        int          we_mid;
        vec_t        t;

        tests   = 0;
        fails   = 0;
        fd_cnt  = 0;
        rst_n   = 1'b0;
        cs_n    = 1'b1;
        sck     = 1'b0;
        sio_in  = 1'b1;
        temp_in = '0;
        temp_we = 1'b0;

        // Master frame while reset is held: outputs must stay at reset values
        repeat (3) @(negedge clk);
        run_frame(16, 16'h0000, -1, '0, 1'b0, rd, oe_bad, rst_bad);
        chk("reset_hold_outputs", 32'(rst_bad), 32'd0);
        chk("reset_no_frame_done", 32'(fd_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_sio_oe", {31'd0, sio_oe}, 32'd0);
        chk("idle_sio_out", {31'd0, sio_out}, 32'd1);
        chk("idle_shutdown", {31'd0, shutdown}, 32'd0);
        chk("idle_cmd_word", {16'd0, cmd_word}, 32'd0);

        // nbits, wdata, we_pre, pre_val, we_mid, mid_val, exp_rd, exp_cmd, exp_shdn
        vecs.push_back('{16, 16'h0000, 1'b1, 11'h064, -1, 11'h000, 16'h0C9F, 16'h0000, 1'b0});
        vecs.push_back('{16, 16'h0000, 1'b1, 11'h7D8, -1, 11'h000, 16'hFB1F, 16'h0000, 1'b0});
        vecs.push_back('{32, 16'h00FF, 1'b0, 11'h000, -1, 11'h000, 16'hFB1F, 16'h00FF, 1'b1});
        vecs.push_back('{16, 16'h0000, 1'b0, 11'h000, -1, 11'h000, 16'h8100, 16'h00FF, 1'b1});
        vecs.push_back('{32, 16'h0000, 1'b0, 11'h000, -1, 11'h000, 16'h8100, 16'h0000, 1'b0});
        vecs.push_back('{16, 16'h0000, 1'b0, 11'h000, -1, 11'h000, 16'hFB1F, 16'h0000, 1'b0});
        vecs.push_back('{16, 16'h0000, 1'b0, 11'h000,  3, 11'h064, 16'hFB1F, 16'h0000, 1'b0});
        vecs.push_back('{16, 16'h0000, 1'b0, 11'h000, -1, 11'h000, 16'h0C9F, 16'h0000, 1'b0});
        vecs.push_back('{ 8, 16'h0000, 1'b0, 11'h000, -1, 11'h000, 16'h0C9F, 16'h0000, 1'b0});
        vecs.push_back('{24, 16'h00FF, 1'b0, 11'h000, -1, 11'h000, 16'h0C9F, 16'h0000, 1'b0});
        vecs.push_back('{32, 16'h12FF, 1'b0, 11'h000, -1, 11'h000, 16'h0C9F, 16'h12FF, 1'b1});
        vecs.push_back('{32, 16'hAB5A, 1'b0, 11'h000, -1, 11'h000, 16'h8100, 16'hAB5A, 1'b1});
        vecs.push_back('{32, 16'h3400, 1'b0, 11'h000, -1, 11'h000, 16'h8100, 16'h3400, 1'b0});
        vecs.push_back('{16, 16'h0000, 1'b1, 11'h400, -1, 11'h000, 16'h801F, 16'h3400, 1'b0});

        foreach (vecs[k]) begin
            t = vecs[k];
            if (t.we_pre) pulse_we(t.pre_val);
            fd0 = fd_cnt;
            run_frame(t.nbits, t.wdata, t.we_mid, t.mid_val, 1'b1, rd, oe_bad, rst_bad);
            n = (t.nbits < 16) ? t.nbits : 16;
            chk($sformatf("vec%0d_read", k), {16'd0, rd}, {16'd0, t.exp_rd >> (16 - n)});
            chk($sformatf("vec%0d_cmd_word", k), {16'd0, cmd_word}, {16'd0, t.exp_cmd});
            chk($sformatf("vec%0d_shutdown", k), {31'd0, shutdown}, {31'd0, t.exp_shdn});
            chk($sformatf("vec%0d_frame_done", k), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("vec%0d_sio_oe", k), 32'(oe_bad), 32'd0);
        end

        // SCK activity with CS high must be invisible
        fd0 = fd_cnt;
        oe_bad = 0;
        for (int i = 0; i < 20; i++) begin
            sck = ~sck;
            repeat (H) @(negedge clk);
            if (sio_oe !== 1'b0) oe_bad++;
        end
        sck = 1'b0;
        repeat (12) @(negedge clk);
        chk("sck_idle_sio_oe", 32'(oe_bad), 32'd0);
        chk("sck_idle_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("sck_idle_cmd_word", {16'd0, cmd_word}, 32'h0000_3400);
        run_frame(16, 16'h0000, -1, '0, 1'b1, rd, oe_bad, rst_bad);
        chk("sck_idle_next_read", {16'd0, rd}, 32'h0000_801F);

        // Reset in the middle of a write phase, then a clean frame
        pulse_we(11'h123);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
            repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_sio_oe", {31'd0, sio_oe}, 32'd0);
        chk("midreset_sio_out", {31'd0, sio_out}, 32'd1);
        chk("midreset_cmd_word", {16'd0, cmd_word}, 32'd0);
        cs_n  = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        fd0 = fd_cnt;
        run_frame(16, 16'h0000, -1, '0, 1'b1, rd, oe_bad, rst_bad);
        chk("midreset_next_read", {16'd0, rd}, 32'h0000_001F);
        chk("midreset_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Randomized frames against a frame-level reference model
        m_temp = '0;
        m_cmd  = '0;
        m_shdn = 1'b0;
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 5))
                0:       nbits = 0;
                1:       nbits = $urandom_range(1, 15);
                2:       nbits = 16;
                3:       nbits = $urandom_range(17, 31);
                default: nbits = $urandom_range(32, 34);
            endcase
            wdata = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       wdata[7:0] = 8'hFF;
                1:       wdata[7:0] = 8'h00;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                v = 11'($urandom);
                pulse_we(v);
                m_temp = v;
            end
            mid_val = 11'($urandom);
            we_mid  = (nbits > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, nbits - 1)) : -1;
            exp_word = m_shdn ? 16'h8100 : {m_temp, 5'b11111};
            fd0 = fd_cnt;
            run_frame(nbits, wdata, we_mid, mid_val, 1'b1, rd, oe_bad, rst_bad);
            if (nbits >= 32) begin
                m_cmd = wdata;
                if (wdata[7:0] == 8'hFF) m_shdn = 1'b1;
                else if (wdata[7:0] == 8'h00) m_shdn = 1'b0;
            end
            if (we_mid >= 0) m_temp = mid_val;
            n = (nbits < 16) ? nbits : 16;
            chk($sformatf("rnd%0d_read_n%0d", r, nbits), {16'd0, rd}, {16'd0, exp_word >> (16 - n)});
            chk($sformatf("rnd%0d_cmd_word", r), {16'd0, cmd_word}, {16'd0, m_cmd});
            chk($sformatf("rnd%0d_shutdown", r), {31'd0, shutdown}, {31'd0, m_shdn});
            chk($sformatf("rnd%0d_frame_done", r), 32'(fd_cnt - fd0), (nbits > 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_sio_oe", r), 32'(oe_bad), 32'd0);
        end

        // Final read confirms any parked temperature reached the read word
        exp_word = m_shdn ? 16'h8100 : {m_temp, 5'b11111};
        run_frame(16, 16'h0000, -1, '0, 1'b1, rd, oe_bad, rst_bad);
        chk("final_read", {16'd0, rd}, {16'd0, exp_word});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
